// File: rtl/sobel_window_builder.sv
// Shared pixel/matrix types and the 3x3 window builder that feeds the combinational Sobel core.
// Raster pixels pass through two line buffers; only fully interior windows are emitted.
package sobel_control_pkg;
  localparam int PIXEL_WIDTH = 8;

  typedef struct packed {
    logic [PIXEL_WIDTH-1:0] pix0;
    logic [PIXEL_WIDTH-1:0] pix1;
    logic [PIXEL_WIDTH-1:0] pix2;
  } sobel_vector;

  typedef struct packed {
    sobel_vector vector0;
    sobel_vector vector1;
    sobel_vector vector2;
  } sobel_matrix;
endpackage

module sobel_window_builder
  import sobel_control_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [PIXEL_WIDTH-1:0] pixel_i,
  input  logic                   pixel_valid_i,
  input  logic                   sof_i,
  output logic                   pixel_ready_o,
  output sobel_matrix            matrix_o,
  output logic                   matrix_valid_o,
  input  logic                   matrix_ready_i,
  output logic                   frame_done_o
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] row;
  logic [RW-1:0] cur_row;
  logic          accept;
  logic          emit;
  logic          at_last_col;
  logic          at_last_row;

  logic [PIXEL_WIDTH-1:0] lb_top [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb_mid [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] top_pix;
  logic [PIXEL_WIDTH-1:0] mid_pix;

  sobel_matrix window;
  logic        matrix_valid;
  logic        frame_done;

  assign pixel_ready_o = !matrix_valid || matrix_ready_i;
  assign accept        = pixel_valid_i && pixel_ready_o;

  // sof_i forces the current beat to (0,0), discarding whatever the counters held
  assign cur_col     = sof_i ? '0 : col;
  assign cur_row     = sof_i ? '0 : row;
  assign at_last_col = (cur_col == LAST_COL);
  assign at_last_row = (cur_row == LAST_ROW);
  assign emit        = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  assign top_pix = lb_top[cur_col];
  assign mid_pix = lb_mid[cur_col];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_last_col) begin
        col <= '0;
        row <= at_last_row ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Line buffer contents need no reset: rows 0 and 1 of every frame overwrite them before use
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb_top[cur_col] <= mid_pix;
      lb_mid[cur_col] <= pixel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      window <= '0;
    end else if (accept) begin
      window.vector0.pix0 <= window.vector0.pix1;
      window.vector0.pix1 <= window.vector0.pix2;
      window.vector0.pix2 <= top_pix;
      window.vector1.pix0 <= window.vector1.pix1;
      window.vector1.pix1 <= window.vector1.pix2;
      window.vector1.pix2 <= mid_pix;
      window.vector2.pix0 <= window.vector2.pix1;
      window.vector2.pix1 <= window.vector2.pix2;
      window.vector2.pix2 <= pixel_i;
    end
  end

  // Windows straddling a row wrap (c<2) or lacking two rows above (r<2) never raise valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      matrix_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      if (emit) begin
        matrix_valid <= 1'b1;
      end else if (matrix_ready_i) begin
        matrix_valid <= 1'b0;
      end
      frame_done <= accept && at_last_col && at_last_row;
    end
  end

  assign matrix_o       = window;
  assign matrix_valid_o = matrix_valid;
  assign frame_done_o   = frame_done;

endmodule

// File: tb/tb_sobel_window_builder.sv
// Self-checking bench for sobel_window_builder on a 4x4 frame: a frame-array reference
// model is compared every cycle, plus scenario checks against hand-computed windows.
module tb_sobel_window_builder;
  import sobel_control_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        sof;
  logic        pixel_ready;
  sobel_matrix matrix;
  logic        matrix_valid;
  logic        matrix_ready;
  logic        frame_done;

  always #5 clk = ~clk;

  sobel_window_builder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pixel_i       (pixel),
    .pixel_valid_i (pixel_valid),
    .sof_i         (sof),
    .pixel_ready_o (pixel_ready),
    .matrix_o      (matrix),
    .matrix_valid_o(matrix_valid),
    .matrix_ready_i(matrix_ready),
    .frame_done_o  (frame_done)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic sobel_matrix mk(input logic [7:0] a, b, c, d, e, f, g, h, i);
    sobel_matrix m;
    m.vector0.pix0 = a; m.vector0.pix1 = b; m.vector0.pix2 = c;
    m.vector1.pix0 = d; m.vector1.pix1 = e; m.vector1.pix2 = f;
    m.vector2.pix0 = g; m.vector2.pix1 = h; m.vector2.pix2 = i;
    return m;
  endfunction

  // Reference model: remembers the frame as a 2-D array and builds windows straight from it
  logic [7:0]  img [H][W];
  int          m_r = 0;
  int          m_c = 0;
  bit          m_valid = 0;
  bit          m_done = 0;
  sobel_matrix m_win = '0;
  sobel_matrix model_emitted[$];

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    int r, c, k;
    if (!rst_n) begin
      m_r = 0; m_c = 0; m_valid = 0; m_done = 0; m_win = '0;
    end else begin
      acc = pixel_valid && (!m_valid || matrix_ready);
      m_done = 0;
      if (acc) begin
        r = sof ? 0 : m_r;
        c = sof ? 0 : m_c;
        img[r][c] = pixel;
        if (r >= 2 && c >= 2) begin
          m_valid = 1;
          m_win = mk(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                     img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                     img[r][c-2],   img[r][c-1],   img[r][c]);
          model_emitted.push_back(m_win);
        end else if (matrix_ready) begin
          m_valid = 0;
        end
        m_done = (r == H-1) && (c == W-1);
        k = (r*W + c + 1) % (W*H);
        m_r = k / W;
        m_c = k % W;
      end else if (matrix_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("matrix_valid", matrix_valid, m_valid);
    checkOutput("frame_done", frame_done, m_done);
    checkOutput("pixel_ready", pixel_ready, !m_valid || matrix_ready);
    if (m_valid) checkOutput("matrix", matrix, m_win);
  end

  sobel_matrix got[$];
  int          done_count = 0;

  always @(negedge clk) begin
    if (rst_n && matrix_valid && matrix_ready) got.push_back(matrix);
    if (frame_done) done_count++;
  end

  bit rand_ready = 0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      matrix_ready = 1'($urandom_range(0, 1));
    end
  end

  sobel_matrix win_first;
  sobel_matrix win_last;
  sobel_matrix ref_list[4];

  task automatic applyStimulus(input logic [7:0] value, input bit first, input int max_gap);
    int gap;
    int waited;
    bit accepted;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    pixel_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
    pixel = value; sof = first; pixel_valid = 1;
    waited = 0; accepted = 0;
    while (!accepted) begin
      @(negedge clk);
      accepted = pixel_ready;
      @(posedge clk); #1;
      waited++;
      if (!accepted && waited > 200) begin
        checkOutput("accept_timeout", 0, 1);
        accepted = 1;
      end
    end
    pixel_valid = 0; sof = 0;
  endtask

  task automatic doReset();
    rst_n = 0; pixel_valid = 0; sof = 0; pixel = 0; matrix_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic clearScore();
    got.delete(); model_emitted.delete(); done_count = 0;
  endtask

  task automatic sendFrame(input int n, input bit with_sof, input int max_gap);
    for (int p = 0; p < n; p++) applyStimulus(8'(p), with_sof && (p == 0), max_gap);
  endtask

  task automatic drain();
    pixel_valid = 0; matrix_ready = 1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_window_count"}, got.size(), 4);
    checkOutput({tag, "_done_count"}, done_count, 1);
    for (int i = 0; i < 4 && i < got.size(); i++)
      checkOutput($sformatf("%s_window%0d", tag, i), got[i], ref_list[i]);
    if (model_emitted.size() > 0) checkOutput({tag, "_model_first"}, model_emitted[0], win_first);
  endtask

  initial begin
    win_first = mk(0, 1, 2, 4, 5, 6, 8, 9, 10);
    win_last  = mk(5, 6, 7, 9, 10, 11, 13, 14, 15);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        ref_list[(r-2)*2 + (c-2)] = mk(8'(4*(r-2)+c-2), 8'(4*(r-2)+c-1), 8'(4*(r-2)+c),
                                       8'(4*(r-1)+c-2), 8'(4*(r-1)+c-1), 8'(4*(r-1)+c),
                                       8'(4*r+c-2),     8'(4*r+c-1),     8'(4*r+c));
    doReset();
    checkOutput("reset_valid", matrix_valid, 0);
    checkOutput("reset_matrix", matrix, 0);
    checkOutput("reset_done", frame_done, 0);

    $display("[TB] continuous frame");
    clearScore();
    for (int p = 0; p < 16; p++) begin
      applyStimulus(8'(p), p == 0, 0);
      if (p == 9) checkOutput("no_valid_before_10", matrix_valid, 0);
      if (p == 10) begin
        checkOutput("first_valid", matrix_valid, 1);
        checkOutput("first_window", matrix, win_first);
      end
      if (p == 12 || p == 13) checkOutput($sformatf("no_wrap_window_%0d", p), matrix_valid, 0);
      if (p == 15) begin
        checkOutput("done_pulse", frame_done, 1);
        checkOutput("last_window", matrix, win_last);
      end
    end
    @(posedge clk); #1;
    checkOutput("done_one_cycle", frame_done, 0);
    drain();
    checkFrame("continuous");

    $display("[TB] backpressure");
    doReset(); clearScore();
    for (int p = 0; p <= 10; p++) applyStimulus(8'(p), p == 0, 0);
    matrix_ready = 0; pixel = 8'd11; pixel_valid = 1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_ready_low", pixel_ready, 0);
      checkOutput("bp_hold", matrix, win_first);
      @(posedge clk); #1;
    end
    matrix_ready = 1;
    for (int p = 11; p < 16; p++) applyStimulus(8'(p), 0, 0);
    drain();
    checkFrame("backpressure");

    $display("[TB] gapped input");
    doReset(); clearScore();
    sendFrame(16, 1, 3);
    drain();
    checkFrame("gapped");

    $display("[TB] restart");
    doReset(); clearScore();
    sendFrame(7, 1, 0);
    sendFrame(16, 1, 0);
    drain();
    checkFrame("restart");

    $display("[TB] reset mid-frame");
    doReset(); clearScore();
    sendFrame(10, 1, 0);
    rst_n = 0;
    #1;
    checkOutput("midreset_valid", matrix_valid, 0);
    checkOutput("midreset_done", frame_done, 0);
    checkOutput("midreset_matrix", matrix, 0);
    @(posedge clk); #1 rst_n = 1;
    clearScore();
    sendFrame(16, 0, 0);
    drain();
    checkFrame("midreset");

    $display("[TB] random frames");
    doReset(); clearScore();
    rand_ready = 1;
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 16; p++) applyStimulus(8'($urandom_range(0, 255)), p == 0, 2);
    rand_ready = 0;
    @(posedge clk); #2;
    drain();
    checkOutput("random_model_count", model_emitted.size(), 12);
    checkOutput("random_window_count", got.size(), model_emitted.size());
    checkOutput("random_done_count", done_count, 3);
    for (int i = 0; i < got.size() && i < model_emitted.size(); i++)
      checkOutput($sformatf("random_window%0d", i), got[i], model_emitted[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
